// File: rtl/comparator_pkg.sv
// rtl/comparator_pkg.sv - shared word type and carry-lookahead helper for the comparator
package comparator_pkg;

    localparam int XLEN = 64;
    localparam int CLA_W = 4;
    localparam int CLA_GROUPS = XLEN / CLA_W;

    typedef logic [XLEN-1:0] word_t;

    // One 4-bit carry-lookahead group: returns {carry_out, sum[3:0]}.
    // Carries are formed from generate/propagate terms, never from a "+".
    function automatic logic [CLA_W:0] cla4(
        input logic [CLA_W-1:0] x,
        input logic [CLA_W-1:0] y,
        input logic             cin
    );
        logic [CLA_W-1:0] g;
        logic [CLA_W-1:0] p;
        logic [CLA_W-1:0] c;
        logic             cout;
        g    = x & y;
        p    = x ^ y;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        return {cout, p ^ c};
    endfunction

endpackage

// File: rtl/comparator_adder64b.sv
// rtl/comparator_adder64b.sv - 64-bit add/subtract built from 16 rippled CLA groups
module adder64b
    import comparator_pkg::*;
(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        sub,
    output logic [63:0] s,
    output logic        c_o
);

    logic [CLA_W:0]   grp;
    logic [CLA_W-1:0] bx;
    logic             carry;

    // Each group resolves its carries internally; only the group carry-out ripples on.
    always_comb begin
        s     = '0;
        grp   = '0;
        bx    = '0;
        carry = sub;
        for (int i = 0; i < CLA_GROUPS; i++) begin
            bx                   = b[i*CLA_W +: CLA_W] ^ {CLA_W{sub}};
            grp                  = cla4(a[i*CLA_W +: CLA_W], bx, carry);
            s[i*CLA_W +: CLA_W]  = grp[CLA_W-1:0];
            carry                = grp[CLA_W];
        end
        c_o = carry;
    end

endmodule

// File: rtl/comparator.sv
// rtl/comparator.sv - registered 64-bit difference with equal/unsigned/signed less-than flags
module comparator
    import comparator_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        valid_o,
    output logic [63:0] s,
    output logic        c_o,
    output logic        eq,
    output logic        lu,
    output logic        ls
);

    word_t diff;
    logic  diff_co;
    logic  eq_d;
    logic  lu_d;
    logic  ls_d;

    adder64b u_adder (
        .a   (a),
        .b   (b),
        .sub (1'b1),
        .s   (diff),
        .c_o (diff_co)
    );

    // Flags from the subtraction; when signs differ the difference bit may have
    // overflowed, so the sign of a alone decides the signed ordering.
    always_comb begin
        eq_d = (diff == '0);
        lu_d = ~diff_co;
        ls_d = (a[XLEN-1] != b[XLEN-1]) ? a[XLEN-1] : diff[XLEN-1];
    end

    // Results are captured every edge; valid only tags which ones carry meaning.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_o <= 1'b0;
            s       <= '0;
            c_o     <= 1'b0;
            eq      <= 1'b0;
            lu      <= 1'b0;
            ls      <= 1'b0;
        end else begin
            valid_o <= valid_i;
            s       <= diff;
            c_o     <= diff_co;
            eq      <= eq_d;
            lu      <= lu_d;
            ls      <= ls_d;
        end
    end

endmodule

// File: tb/tb_comparator.sv
// tb/tb_comparator.sv - directed and random self-checking bench for comparator
module tb_comparator;

    logic        clk;
    logic        reset;
    logic        valid_i;
    logic [63:0] a;
    logic [63:0] b;
    logic        valid_o;
    logic [63:0] s;
    logic        c_o;
    logic        eq;
    logic        lu;
    logic        ls;

    int checks;
    int errors;

    logic [68:0] obs;
    logic [68:0] exp_v;

    comparator dut (
        .clk     (clk),
        .reset   (reset),
        .valid_i (valid_i),
        .a       (a),
        .b       (b),
        .valid_o (valid_o),
        .s       (s),
        .c_o     (c_o),
        .eq      (eq),
        .lu      (lu),
        .ls      (ls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    assign obs = {valid_o, s, c_o, eq, lu, ls};

    task automatic test_reset();
        reset   = 1'b1;
        valid_i = 1'b1;
        a       = 64'h0000_0000_0000_0009;
        b       = 64'h0000_0000_0000_0002;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (obs !== 69'h0) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs, 69'h0);
        end
        reset = 1'b0;
        a     = 64'd5;
        b     = 64'd5;
        @(posedge clk); #1;
        exp_v = {1'b1, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL first_after_reset: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_vectors();
        logic [63:0] va [8];
        logic [63:0] vb [8];
        logic        vv [8];
        logic [68:0] ve [8];
        va = '{64'd5, 64'd0, 64'h8000_0000_0000_0000, 64'd3,
               64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF};
        vb = '{64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd7,
               64'd3, 64'd0, 64'd0, 64'h8000_0000_0000_0000};
        vv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        ve = '{{1'b1, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0},
               {1'b1, 64'h1, 1'b0, 1'b0, 1'b1, 1'b0},
               {1'b1, 64'h1, 1'b1, 1'b0, 1'b0, 1'b1},
               {1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 1'b1, 1'b1},
               {1'b1, 64'h4, 1'b1, 1'b0, 1'b0, 1'b0},
               {1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0},
               {1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1},
               {1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0}};
        for (int i = 0; i < 8; i++) begin
            a       = va[i];
            b       = vb[i];
            valid_i = vv[i];
            @(posedge clk); #1;
            checks++;
            if (obs !== ve[i]) begin
                errors++;
                $display("FAIL vector_%0d: got %h expected %h", i, obs, ve[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        a       = 64'd1;
        b       = 64'd2;
        valid_i = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        a     = 64'd10;
        b     = 64'd20;
        @(posedge clk); #1;
        checks++;
        if (obs !== 69'h0) begin
            errors++;
            $display("FAIL reset_midstream: got %h expected %h", obs, 69'h0);
        end
        reset = 1'b0;
        a     = 64'h8000_0000_0000_0000;
        b     = 64'h7FFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1;
        exp_v = {1'b1, 64'h1, 1'b1, 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL release_after_midstream_reset: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] ra;
        logic [63:0] rb;
        logic        rv;
        for (int i = 0; i < 1000; i++) begin
            ra = {$urandom, $urandom};
            rb = ($urandom_range(0, 7) == 0) ? ra : {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rb[63] = ~ra[63];
            rv = ($urandom_range(0, 4) != 0);
            a       = ra;
            b       = rb;
            valid_i = rv;
            exp_v   = {rv, ra - rb, !(ra < rb), ra == rb, ra < rb, $signed(ra) < $signed(rb)};
            @(posedge clk); #1;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL random_%0d a=%h b=%h: got %h expected %h", i, ra, rb, obs, exp_v);
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        valid_i = 1'b0;
        a       = '0;
        b       = '0;
        test_reset();
        test_vectors();
        test_reset_midstream();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/comparator.md
COMPARATOR -- requirements
Module: comparator

Interface
REQ-001 Parameters: none; datapath width is fixed at 64 bits.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 valid_i  input  1  operand pair on a/b is valid this cycle.
REQ-006 a  input  64  operand A, two's complement or unsigned.
REQ-007 b  input  64  operand B, two's complement or unsigned.
REQ-008 valid_o  output  1  registered results correspond to a valid input.
REQ-009 s  output  64  registered difference A - B, modulo 2^64.
REQ-010 c_o  output  1  registered carry-out of A + ~B + 1; 1 means no borrow.
REQ-011 eq  output  1  registered A == B.
REQ-012 lu  output  1  registered A < B, unsigned.
REQ-013 ls  output  1  registered A < B, signed two's complement.

Function
REQ-014 The difference SHALL be computed as a + (~b) + 1 by one adder64b instance with sub tied to 1.
REQ-015 adder64b ports SHALL be a[63:0], b[63:0], sub, s[63:0], c_o.
REQ-016 adder64b SHALL compute s = a + (b XOR {64{sub}}) + sub, with c_o as the carry out of bit 63.
REQ-017 eq SHALL be 1 exactly when all 64 bits of the difference are zero.
REQ-018 lu SHALL equal NOT c_o of the subtraction.
REQ-019 ls SHALL equal a[63] when a[63] != b[63]; otherwise it SHALL equal difference bit 63.
REQ-020 ls SHALL be correct across signed overflow, e.g. most-negative versus most-positive.
REQ-021 All outputs SHALL be registered with exactly one cycle of latency.
REQ-022 The result of the operands present at edge N SHALL be visible after edge N.
REQ-023 Output registers SHALL update on every non-reset edge regardless of valid_i.
REQ-024 valid_o SHALL be valid_i delayed by one cycle.
REQ-025 No handshake or back-pressure; a new operand pair is accepted every cycle.
REQ-026 There SHALL be no internal state besides the output and valid registers.

Reset
REQ-027 With reset high at a rising edge, s, c_o, eq, lu, ls and valid_o SHALL all become 0.
REQ-028 Reset SHALL override valid_i; an operand pair presented during reset produces no result.
REQ-029 The first result after reset is released SHALL appear one edge after deassertion.

Structure
REQ-030 Shared package SHALL hold XLEN = 64 and a typedef for the 64-bit word.
REQ-031 adder64b SHALL be a separate sub-module, purely combinational.
REQ-032 adder64b SHALL be built structurally as 16 four-bit carry-lookahead groups with ripple between groups.
REQ-033 adder64b SHALL NOT use a behavioral "+" operator.
REQ-034 Flag logic (eq, lu, ls) SHALL be combinational inside comparator, ahead of the output registers.

Verification
REQ-035 a=5, b=5, valid_i=1 -> next cycle: s=0, c_o=1, eq=1, lu=0, ls=0, valid_o=1.
REQ-036 a=0, b=0xFFFF_FFFF_FFFF_FFFF -> s=1, c_o=0, eq=0, lu=1, ls=0.
REQ-037 a=0x8000_0000_0000_0000, b=0x7FFF_FFFF_FFFF_FFFF -> s=1, c_o=1, eq=0, lu=0, ls=1.
REQ-038 a=3, b=7 -> s=0xFFFF_FFFF_FFFF_FFFC, c_o=0, eq=0, lu=1, ls=1.
REQ-039 Reset asserted mid-stream with valid_i=1 -> after that edge all outputs and valid_o are 0.
REQ-040 Reset test: a correct result SHALL follow one edge after reset deasserts.
REQ-041 1000 random a/b pairs, new pair every cycle -> each output matches its golden model, one cycle delayed.
REQ-042 Golden models: a<b unsigned, $signed(a)<$signed(b), a==b, a-b; zero mismatches SHALL be reported.
